// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-atomic arbiter sharing one async-FIFO write port among N requesters (wclk domain).
// Optional per-requester transfer counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                 wclk,
  input  logic                 arst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  input  logic                 w_full,
  output logic                 w_en,
  output logic [WIDTH-1:0]     data_in,
  output logic [N-1:0]         grant,
  output logic                 busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [N*16-1:0]      stat_words
`endif
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                     state_q;
  logic [N-1:0]               grant_q;
  logic [PW-1:0]              ptr_q;
  logic [CW-1:0]              cnt_q;
  logic [N-1:0][WIDTH-1:0]    req_data_v;
  logic [PW-1:0]              win_idx, cand;
  logic                       win_found, xfer, burst_end;

  assign req_data_v = req_data;

  // Search starts one past the last owner so the previous winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr_q) + i) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign busy      = (state_q == GRANT);
  assign grant     = grant_q;
  assign xfer      = busy & req_valid[ptr_q] & ~w_full;
  assign w_en      = xfer;
  assign req_ready = {N{xfer}} & grant_q;
  assign data_in   = busy ? req_data_v[ptr_q] : '0;
  assign burst_end = req_last[ptr_q] | (cnt_q == CW'(MAX_BURST - 1));

  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q <= GRANT;
            grant_q <= N'(1) << win_idx;
            ptr_q   <= win_idx;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          // Grant is held through valid gaps and full stalls; only a transfer can end a burst.
          if (xfer) begin
            if (burst_end) begin
              state_q <= IDLE;
              grant_q <= '0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N-1:0][15:0] stat_q, stat_d;

  // Clear wins over a same-cycle increment; counters stick at 0xFFFF.
  always_comb begin
    stat_d = stat_q;
    for (int k = 0; k < N; k++) begin
      if (stat_clr)
        stat_d[k] = '0;
      else if (xfer && grant_q[k] && stat_q[k] != 16'hFFFF)
        stat_d[k] = stat_q[k] + 16'd1;
    end
  end

  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) stat_q <= '0;
    else         stat_q <= stat_d;
  end

  assign stat_words = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-backed requesters feed the DUT, a scoreboard
// of {grant, data} in expected arbitration order is checked on every FIFO write.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 8;

  logic             wclk = 1'b0;
  logic             arst_n;
  logic [N-1:0]     req_valid, req_last, req_ready, grant;
  logic [N*W-1:0]   req_data;
  logic             w_full, w_en, busy;
  logic [W-1:0]     data_in;
`ifdef FIFO_WR_ARB_STATS_EN
  logic             stat_clr;
  logic [N*16-1:0]  stat_words;
`endif

  int               errors = 0;
  int               checks = 0;
  logic [N+W-1:0]   sb[$];
  logic [W:0]       mem [N][64];
  int               hd [N] = '{default: 0};
  int               tl [N] = '{default: 0};
  logic [31:0]      pat;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .arst_n    (arst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .w_full    (w_full),
    .w_en      (w_en),
    .data_in   (data_in),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_words (stat_words)
`endif
  );

  // Requester model: each presents the head of its word queue, popped on req_ready.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_valid[k]         = (hd[k] != tl[k]);
      req_data[k*W +: W]   = mem[k][hd[k][5:0]][W-1:0];
      req_last[k]          = mem[k][hd[k][5:0]][W];
    end
  end

  always @(posedge wclk) begin
    for (int k = 0; k < N; k++)
      if (req_ready[k]) hd[k] <= hd[k] + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic rq_push(input int k, input logic [W-1:0] d, input logic last);
    mem[k][tl[k][5:0]] = {last, d};
    tl[k]++;
  endtask

  task automatic sb_push(input int k, input logic [W-1:0] d);
    logic [N-1:0] g;
    g    = '0;
    g[k] = 1'b1;
    sb.push_back({g, d});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge wclk);
      n++;
    end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  // Every FIFO write must match the next scoreboard entry and never occur while full.
  always @(negedge wclk) begin
    if (w_en) begin
      chk("wen_while_full", {63'd0, w_full}, 64'd0);
      chk("ready_matches_grant", {60'd0, req_ready}, {60'd0, grant});
      chk("write_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0)
        chk("write_grant_data", {52'd0, grant, data_in}, {52'd0, sb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0;
    w_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #2;
    chk("rst_grant", {60'd0, grant}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wen", {63'd0, w_en}, 64'd0);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_data", {56'd0, data_in}, 64'd0);
    repeat (2) step();
    arst_n = 1'b1;

    // Single requester, three-word burst closed by req_last.
    step();
    rq_push(0, 8'h11, 1'b0); rq_push(0, 8'h22, 1'b0); rq_push(0, 8'h33, 1'b1);
    sb_push(0, 8'h11); sb_push(0, 8'h22); sb_push(0, 8'h33);
    @(negedge wclk);
    chk("s1_arb_grant", {60'd0, grant}, 64'd0);
    chk("s1_arb_wen", {63'd0, w_en}, 64'd0);
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wclk);
      chk("s1_grant", {60'd0, grant}, 64'd1);
      pat = {pat[30:0], w_en};
    end
    chk("s1_wen_run", {32'd0, pat}, 64'h7);
    @(negedge wclk);
    chk("s1_end_grant", {60'd0, grant}, 64'd0);
    chk("s1_end_busy", {63'd0, busy}, 64'd0);
    wait_idle("s1");
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stat_req0", {48'd0, stat_words[15:0]}, 64'd3);
    chk("stat_others", {16'd0, stat_words[63:16]}, 64'd0);
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stat_cleared", stat_words, 64'd0);
`endif

    // All four requesters, two 2-word bursts each; owner 0 just finished so 1 goes first.
    step();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) begin
        rq_push(k, 8'(k*16 + r*2),     1'b0);
        rq_push(k, 8'(k*16 + r*2 + 1), 1'b1);
      end
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < N; j++) begin
        sb_push((j + 1) % N, 8'(((j + 1) % N)*16 + r*2));
        sb_push((j + 1) % N, 8'(((j + 1) % N)*16 + r*2 + 1));
      end
    pat = '0;
    repeat (24) begin
      @(negedge wclk);
      pat = {pat[30:0], w_en};
    end
    chk("s2_bubble_pattern", {32'd0, pat}, 64'h6DB6DB);
    wait_idle("s2");

    // Requester 2 streams 12 words; the 8th ends the burst by count alone.
    // The final word carries req_last so the second grant closes.
    step();
    for (int i = 0; i < 12; i++) begin
      rq_push(2, 8'(8'h80 + i), (i == 11));
      sb_push(2, 8'(8'h80 + i));
    end
    pat = '0;
    repeat (14) begin
      @(negedge wclk);
      pat = {pat[30:0], w_en};
    end
    chk("s3_maxburst_pattern", {32'd0, pat}, 64'h1FEF);
    wait_idle("s3");

    // FIFO full for 5 cycles after word 3 of a requester-3 burst.
    step();
    for (int i = 0; i < 6; i++) begin
      rq_push(3, 8'(8'hC0 + i), (i == 5));
      sb_push(3, 8'(8'hC0 + i));
    end
    @(negedge wclk);
    repeat (3) @(negedge wclk);
    step();
    w_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      chk("s4_full_wen", {63'd0, w_en}, 64'd0);
      chk("s4_full_ready", {60'd0, req_ready}, 64'd0);
      chk("s4_full_grant", {60'd0, grant}, 64'h8);
    end
    step();
    w_full = 1'b0;
    @(negedge wclk);
    chk("s4_resume_wen", {63'd0, w_en}, 64'd1);
    chk("s4_resume_data", {56'd0, data_in}, 64'hC3);
    wait_idle("s4");

    // Reset asserted while requester 1 presents word 5.
    step();
    for (int i = 0; i < 8; i++) rq_push(1, 8'(8'h40 + i), (i == 7));
    for (int i = 0; i < 4; i++) sb_push(1, 8'(8'h40 + i));
    @(negedge wclk);
    repeat (4) @(negedge wclk);
    step();
    arst_n = 1'b0;
    #1;
    chk("s5_rst_grant", {60'd0, grant}, 64'd0);
    chk("s5_rst_wen", {63'd0, w_en}, 64'd0);
    chk("s5_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge wclk);
    chk("s5_rst_wen_held", {63'd0, w_en}, 64'd0);
    tl[1] = hd[1];
    rq_push(0, 8'h50, 1'b1); rq_push(1, 8'h60, 1'b1);
    sb_push(0, 8'h50); sb_push(1, 8'h60);
    step();
    arst_n = 1'b1;
    @(negedge wclk);
    chk("s5_arb_grant", {60'd0, grant}, 64'd0);
    @(negedge wclk);
    chk("s5_winner", {60'd0, grant}, 64'd1);
    wait_idle("s5");

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side arbiter for the async FIFO, living entirely in the `wclk` domain.
- Shares the FIFO write port (`w_en`/`data_in`) between N requesters using round-robin, burst-atomic grants.
- Throttles transfers on the FIFO full flag, so no write is ever issued while full.
- Sits between MAC-side producers (e.g. TX frame sources) and the FIFO.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 8, data word width; matches FIFO WIDTH.
- MAX_BURST, 8, maximum words per grant before forced re-arbitration; matches FIFO SIZE.

Ports:
- wclk  in  1  write-domain clock; all logic on its rising edge.
- arst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  requester k has a word on its data slice.
- req_data  in  N*WIDTH  requester k word in bits [k*WIDTH +: WIDTH].
- req_last  in  N  word presented by requester k ends its burst.
- req_ready  out  N  word of requester k accepted this cycle.
- w_full  in  1  FIFO full flag, write-domain synchronous.
- w_en  out  1  FIFO write enable.
- data_in  out  WIDTH  FIFO write data.
- grant  out  N  one-hot current owner; 0 when idle.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, busy=0, burst count=0, last-owner pointer=N-1 (so requester 0 has first priority).
- Reset effects on outputs: `w_en` and `req_ready` are 0 because `grant`=0.
- FSM IDLE -> GRANT:
  - When any `req_valid` is high, register a one-hot grant to the first valid requester searching from pointer+1 upward, wrapping modulo N.
  - Store the winner in the pointer; count=0.
  - Arbitration takes exactly one cycle; no transfer occurs in IDLE.
- FSM GRANT:
  - Transfer condition T = `req_valid[g]` & !`w_full`.
  - `req_ready[g]` = T and `w_en` = T, both combinational.
  - `data_in` = slice g of `req_data` (muxed combinationally, driven whenever granted); `data_in` = 0 when idle.
  - Non-granted `req_ready` bits are 0.
  - On T: count += 1.
  - If T & (`req_last[g]` | count==MAX_BURST-1): return to IDLE, grant=0, count=0.
  - Otherwise stay in GRANT.
- Burst atomicity:
  - If the granted requester deasserts `req_valid` mid-burst, the grant is held; there is no timeout and other requesters wait.
- Full FIFO:
  - While `w_full`=1, T=0, the grant is held, and `w_en` stays 0 regardless of `req_valid`.
- Burst boundary:
  - A burst of exactly MAX_BURST words ends on its last word even without `req_last`.
  - The requester resumes in a later grant.
- Bubble:
  - Exactly one idle cycle (`w_en`=0) between consecutive bursts, including back-to-back bursts by the same sole requester.
- Counter width: clog2(MAX_BURST)+1 bits; never exceeds MAX_BURST-1.
- Simultaneous requests: resolved purely by round-robin order. After owner k completes, priority order is k+1, k+2, … wrapping.
- Mid-burst reset: drops the grant immediately (async); the in-flight burst is truncated; no `w_en` after `arst_n` falls.

Optional Feature:
- Macro: `FIFO_WR_ARB_STATS_EN`.
- When defined:
  - Adds input `stat_clr` (1) and output `stat_words` (N*16).
  - One 16-bit counter per requester, incremented on each of its transfers, saturating at 0xFFFF.
  - Counters are cleared by reset or by `stat_clr`; `stat_clr` has priority over an increment in the same cycle.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then `req_valid`=4'b0001, 3 words 0x11,0x22,0x33 with `req_last` on 0x33:
  - `grant`=0001 one cycle after `req_valid`.
  - `w_en` high for 3 consecutive cycles with those data.
  - Then IDLE, `grant`=0.
- All 4 requesters valid continuously with 2-word bursts:
  - Grant order 0,1,2,3,0.
  - Exactly one `w_en`=0 cycle between bursts.
- Requester 2 streams 12 words without `req_last`:
  - Burst ends after 8 words (count hits 7).
  - IDLE for 1 cycle, re-granted; remaining 4 words follow.
- `w_full` forced high for 5 cycles mid-burst after word 3:
  - `w_en`=0 and `req_ready`=0 for those 5 cycles.
  - `grant` unchanged.
  - Word 4 written on the first cycle `w_full`=0.
- `arst_n` pulsed low during word 5 of a burst from requester 1:
  - `grant`=0 and `w_en`=0 immediately.
  - After release with requesters 0 and 1 valid, requester 0 wins.
- With `FIFO_WR_ARB_STATS_EN`:
  - After the first scenario, `stat_words` slice 0 = 3 and other slices = 0.
  - `stat_clr` for one cycle returns all slices to 0.
